// File: rtl/ifid_fetch_buffer.sv
// IF/ID fetch buffer: runs the instruction-memory req/ack handshake, registers the
// returned word into the IF/ID register, holds one skid entry and flags bus timeouts.
module ifid_fetch_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] InstructionAddress_IN,
  input  logic [31:0] InstructionAddressPlus4_IN,
  input  logic        Stall_IN,
  input  logic        Flush_IN,
  output logic        MemReq_OUT,
  output logic [31:0] MemAddr_OUT,
  input  logic        MemAck_IN,
  input  logic [31:0] MemData_IN,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] InstructionAddressPlus4_OUT,
  output logic        Valid_OUT,
  output logic        FetchStall_OUT,
  output logic        BusError_OUT
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q, pc4_d;
  logic             valid_q, valid_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic [31:0]      skid_pc4_q, skid_pc4_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;

  logic mem_req;
  logic fetch_stall;

  always_comb begin
    mem_req     = 1'b0;
    fetch_stall = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_FETCH: begin
          mem_req     = 1'b1;
          fetch_stall = !(MemAck_IN && !Stall_IN);
        end
        ST_HOLD: begin
          mem_req     = 1'b0;
          fetch_stall = 1'b1;
        end
        ST_DRAIN: begin
          mem_req     = 1'b1;
          fetch_stall = 1'b1;
        end
        default: begin
          mem_req     = 1'b0;
          fetch_stall = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_valid_d = skid_valid_q;

    case (state_q)
      ST_FETCH: begin
        if (Flush_IN) begin
          instr_d = NOP_INSTR;
          pc4_d   = 32'h0;
          valid_d = 1'b0;
          if (!MemAck_IN) state_d = ST_DRAIN;
        end else if (MemAck_IN && Stall_IN) begin
          skid_instr_d = MemData_IN;
          skid_pc4_d   = InstructionAddressPlus4_IN;
          skid_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end else if (MemAck_IN) begin
          instr_d = MemData_IN;
          pc4_d   = InstructionAddressPlus4_IN;
          valid_d = 1'b1;
        end else if (!Stall_IN) begin
          valid_d = 1'b0;
        end
      end

      // Memory acks are ignored here: no request is outstanding while holding.
      ST_HOLD: begin
        if (Flush_IN) begin
          instr_d      = NOP_INSTR;
          pc4_d        = 32'h0;
          valid_d      = 1'b0;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (!Stall_IN) begin
          instr_d      = skid_instr_q;
          pc4_d        = skid_pc4_q;
          valid_d      = skid_valid_q;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (MemAck_IN) state_d = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase
  end

  // Consecutive un-acked request cycles; the error flag is sticky until reset.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_req && !MemAck_IN) begin
      if (wait_cnt_q == CNT_MAX) wait_cnt_d = wait_cnt_q;
      else                       wait_cnt_d = wait_cnt_q + 1'b1;
    end
    bus_err_d = bus_err_q | (wait_cnt_d == CNT_MAX);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_FETCH;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_valid_q <= 1'b0;
      wait_cnt_q   <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_valid_q <= skid_valid_d;
      wait_cnt_q   <= wait_cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign MemReq_OUT                  = mem_req;
  assign MemAddr_OUT                 = InstructionAddress_IN;
  assign FetchStall_OUT              = fetch_stall;
  assign Instruction_OUT             = instr_q;
  assign InstructionAddressPlus4_OUT = pc4_q;
  assign Valid_OUT                   = valid_q;
  assign BusError_OUT                = bus_err_q;

endmodule

// File: tb/tb_ifid_fetch_buffer.sv
// Scoreboard bench for ifid_fetch_buffer: expected IF/ID words are queued when the
// memory ack is driven and popped when the IF/ID register is due to load.
module tb_ifid_fetch_buffer;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] InstructionAddress_IN;
  logic [31:0] InstructionAddressPlus4_IN;
  logic        Stall_IN;
  logic        Flush_IN;
  logic        MemReq_OUT;
  logic [31:0] MemAddr_OUT;
  logic        MemAck_IN;
  logic [31:0] MemData_IN;
  logic [31:0] Instruction_OUT;
  logic [31:0] InstructionAddressPlus4_OUT;
  logic        Valid_OUT;
  logic        FetchStall_OUT;
  logic        BusError_OUT;

  localparam logic [31:0] NOP = 32'h0000_0000;

  int checks = 0;
  int fails  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] last_instr;
  logic [31:0] last_pc4;

  ifid_fetch_buffer #(.NOP_INSTR(NOP), .TIMEOUT(16)) dut (
    .CLOCK                       (CLOCK),
    .RESET                       (RESET),
    .InstructionAddress_IN       (InstructionAddress_IN),
    .InstructionAddressPlus4_IN  (InstructionAddressPlus4_IN),
    .Stall_IN                    (Stall_IN),
    .Flush_IN                    (Flush_IN),
    .MemReq_OUT                  (MemReq_OUT),
    .MemAddr_OUT                 (MemAddr_OUT),
    .MemAck_IN                   (MemAck_IN),
    .MemData_IN                  (MemData_IN),
    .Instruction_OUT             (Instruction_OUT),
    .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
    .Valid_OUT                   (Valid_OUT),
    .FetchStall_OUT              (FetchStall_OUT),
    .BusError_OUT                (BusError_OUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_fetch(input logic [31:0] addr, input logic ack, input logic [31:0] data);
    InstructionAddress_IN      = addr;
    InstructionAddressPlus4_IN = addr + 32'd4;
    MemAck_IN                  = ack;
    MemData_IN                 = data;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    Stall_IN = 1'b0; Flush_IN = 1'b0;
    set_fetch(32'h0, 1'b0, 32'h0);
    tick();
    tick();
    checks++; if (Instruction_OUT !== NOP) begin fails++; $display("[TB] FAIL rst_instr: got %h want %h", Instruction_OUT, NOP); end
    checks++; if (InstructionAddressPlus4_OUT !== 32'h0) begin fails++; $display("[TB] FAIL rst_pc4: got %h want 0", InstructionAddressPlus4_OUT); end
    checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %b want 0", Valid_OUT); end
    checks++; if (BusError_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rst_buserr: got %b want 0", BusError_OUT); end
    checks++; if (MemReq_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rst_req: got %b want 0", MemReq_OUT); end
    checks++; if (FetchStall_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rst_stall: got %b want 0", FetchStall_OUT); end
    RESET = 1'b0;
    #1;
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL rst_req_after: got %b want 1", MemReq_OUT); end
    checks++; if (FetchStall_OUT !== 1'b1) begin fails++; $display("[TB] FAIL rst_stall_after: got %b want 1", FetchStall_OUT); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] addr;
    for (int i = 0; i < 3; i++) begin
      addr = 32'hBFC0_0000 + 32'(4 * i);
      set_fetch(addr, 1'b1, 32'(8'h11 * (i + 1)));
      #1;
      checks++; if (FetchStall_OUT !== 1'b0) begin fails++; $display("[TB] FAIL zw_stall[%0d]: got %b want 0", i, FetchStall_OUT); end
      checks++; if (MemAddr_OUT !== addr) begin fails++; $display("[TB] FAIL zw_addr[%0d]: got %h want %h", i, MemAddr_OUT, addr); end
      exp_q.push_back({MemData_IN, addr + 32'd4});
      tick();
      if (exp_q.size() == 0) begin
        checks++; fails++; $display("[TB] FAIL zw_sb_empty[%0d]: got 0 entries want 1", i);
      end else begin
        e = exp_q.pop_front();
        checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL zw_instr[%0d]: got %h want %h", i, Instruction_OUT, e[63:32]); end
        checks++; if (InstructionAddressPlus4_OUT !== e[31:0]) begin fails++; $display("[TB] FAIL zw_pc4[%0d]: got %h want %h", i, InstructionAddressPlus4_OUT, e[31:0]); end
        last_instr = e[63:32]; last_pc4 = e[31:0];
      end
      checks++; if (Valid_OUT !== 1'b1) begin fails++; $display("[TB] FAIL zw_valid[%0d]: got %b want 1", i, Valid_OUT); end
    end
    MemAck_IN = 1'b0;
  endtask

  task automatic test_wait_states();
    set_fetch(32'h0000_0100, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (FetchStall_OUT !== 1'b1) begin fails++; $display("[TB] FAIL ws_stall[%0d]: got %b want 1", i, FetchStall_OUT); end
      tick();
      checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL ws_bubble[%0d]: got %b want 0", i, Valid_OUT); end
    end
    set_fetch(32'h0000_0100, 1'b1, 32'hCAFE_0001);
    #1;
    checks++; if (FetchStall_OUT !== 1'b0) begin fails++; $display("[TB] FAIL ws_stall_ack: got %b want 0", FetchStall_OUT); end
    exp_q.push_back({32'hCAFE_0001, 32'h0000_0104});
    tick();
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL ws_instr: got %h want %h", Instruction_OUT, e[63:32]); end
    checks++; if (Valid_OUT !== 1'b1) begin fails++; $display("[TB] FAIL ws_valid: got %b want 1", Valid_OUT); end
    last_instr = e[63:32]; last_pc4 = e[31:0];
    MemAck_IN = 1'b0;
  endtask

  task automatic test_skid();
    set_fetch(32'h0000_0200, 1'b1, 32'h0000_00AA);
    Stall_IN = 1'b1;
    #1;
    checks++; if (FetchStall_OUT !== 1'b1) begin fails++; $display("[TB] FAIL sk_stall_ack: got %b want 1", FetchStall_OUT); end
    exp_q.push_back({32'h0000_00AA, 32'h0000_0204});
    tick();
    for (int i = 0; i < 2; i++) begin
      MemAck_IN  = (i == 1);
      MemData_IN = 32'hDEAD_BEEF;
      #1;
      checks++; if (Instruction_OUT !== last_instr) begin fails++; $display("[TB] FAIL sk_hold_instr[%0d]: got %h want %h", i, Instruction_OUT, last_instr); end
      checks++; if (MemReq_OUT !== 1'b0) begin fails++; $display("[TB] FAIL sk_req[%0d]: got %b want 0", i, MemReq_OUT); end
      checks++; if (FetchStall_OUT !== 1'b1) begin fails++; $display("[TB] FAIL sk_stall[%0d]: got %b want 1", i, FetchStall_OUT); end
      if (i == 0) tick();
    end
    Stall_IN = 1'b0; MemAck_IN = 1'b0;
    tick();
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL sk_instr: got %h want %h", Instruction_OUT, e[63:32]); end
    checks++; if (InstructionAddressPlus4_OUT !== e[31:0]) begin fails++; $display("[TB] FAIL sk_pc4: got %h want %h", InstructionAddressPlus4_OUT, e[31:0]); end
    checks++; if (Valid_OUT !== 1'b1) begin fails++; $display("[TB] FAIL sk_valid: got %b want 1", Valid_OUT); end
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL sk_req_resume: got %b want 1", MemReq_OUT); end
  endtask

  task automatic test_flush();
    set_fetch(32'h0000_0300, 1'b0, 32'h0);
    Flush_IN = 1'b1;
    tick();
    Flush_IN = 1'b0;
    #1;
    checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL fl_valid: got %b want 0", Valid_OUT); end
    checks++; if (Instruction_OUT !== NOP) begin fails++; $display("[TB] FAIL fl_instr: got %h want %h", Instruction_OUT, NOP); end
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL fl_drain_req: got %b want 1", MemReq_OUT); end
    checks++; if (FetchStall_OUT !== 1'b1) begin fails++; $display("[TB] FAIL fl_drain_stall: got %b want 1", FetchStall_OUT); end
    tick();
    set_fetch(32'h0000_0300, 1'b1, 32'h0000_00BB);
    tick();
    MemAck_IN = 1'b0;
    checks++; if (Instruction_OUT !== NOP) begin fails++; $display("[TB] FAIL fl_discard: got %h want %h", Instruction_OUT, NOP); end
    checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL fl_discard_valid: got %b want 0", Valid_OUT); end
    set_fetch(32'h0000_0400, 1'b1, 32'h1234_5678);
    exp_q.push_back({32'h1234_5678, 32'h0000_0404});
    tick();
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL fl_next_instr: got %h want %h", Instruction_OUT, e[63:32]); end
    checks++; if (Valid_OUT !== 1'b1) begin fails++; $display("[TB] FAIL fl_next_valid: got %b want 1", Valid_OUT); end

    // Flush while holding a skid entry: the skid word must never surface.
    set_fetch(32'h0000_0500, 1'b1, 32'h0000_0055);
    Stall_IN = 1'b1;
    tick();
    MemAck_IN = 1'b0; Flush_IN = 1'b1;
    tick();
    Flush_IN = 1'b0; Stall_IN = 1'b0;
    #1;
    checks++; if (Instruction_OUT !== NOP) begin fails++; $display("[TB] FAIL flh_instr: got %h want %h", Instruction_OUT, NOP); end
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL flh_req: got %b want 1", MemReq_OUT); end
    tick();
    checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL flh_valid: got %b want 0", Valid_OUT); end
    set_fetch(32'h0000_0600, 1'b1, 32'h0000_0066);
    exp_q.push_back({32'h0000_0066, 32'h0000_0604});
    tick();
    MemAck_IN = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL flh_next_instr: got %h want %h", Instruction_OUT, e[63:32]); end
  endtask

  task automatic test_timeout();
    set_fetch(32'h0000_0700, 1'b0, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++; if (BusError_OUT !== 1'b0) begin fails++; $display("[TB] FAIL to_early[%0d]: got %b want 0", i, BusError_OUT); end
    end
    tick();
    checks++; if (BusError_OUT !== 1'b1) begin fails++; $display("[TB] FAIL to_set: got %b want 1", BusError_OUT); end
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL to_req: got %b want 1", MemReq_OUT); end
    tick();
    set_fetch(32'h0000_0700, 1'b1, 32'h0000_0077);
    exp_q.push_back({32'h0000_0077, 32'h0000_0704});
    tick();
    MemAck_IN = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL to_late_instr: got %h want %h", Instruction_OUT, e[63:32]); end
    checks++; if (BusError_OUT !== 1'b1) begin fails++; $display("[TB] FAIL to_sticky: got %b want 1", BusError_OUT); end
  endtask

  task automatic test_reset_mid();
    set_fetch(32'h0000_0800, 1'b1, 32'h0000_0088);
    Stall_IN = 1'b1;
    tick();
    MemAck_IN = 1'b0;
    RESET = 1'b1; Flush_IN = 1'b1;
    #1;
    checks++; if (MemReq_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rm_req_comb: got %b want 0", MemReq_OUT); end
    checks++; if (FetchStall_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rm_stall_comb: got %b want 0", FetchStall_OUT); end
    tick();
    checks++; if (Instruction_OUT !== NOP) begin fails++; $display("[TB] FAIL rm_instr: got %h want %h", Instruction_OUT, NOP); end
    checks++; if (InstructionAddressPlus4_OUT !== 32'h0) begin fails++; $display("[TB] FAIL rm_pc4: got %h want 0", InstructionAddressPlus4_OUT); end
    checks++; if (Valid_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rm_valid: got %b want 0", Valid_OUT); end
    checks++; if (BusError_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rm_buserr: got %b want 0", BusError_OUT); end
    checks++; if (MemReq_OUT !== 1'b0) begin fails++; $display("[TB] FAIL rm_req: got %b want 0", MemReq_OUT); end
    RESET = 1'b0; Flush_IN = 1'b0; Stall_IN = 1'b0;
    #1;
    checks++; if (MemReq_OUT !== 1'b1) begin fails++; $display("[TB] FAIL rm_req_after: got %b want 1", MemReq_OUT); end
    set_fetch(32'h0000_0900, 1'b1, 32'h0000_0099);
    exp_q.push_back({32'h0000_0099, 32'h0000_0904});
    tick();
    MemAck_IN = 1'b0;
    e = exp_q.pop_front();
    checks++; if (Instruction_OUT !== e[63:32]) begin fails++; $display("[TB] FAIL rm_next_instr: got %h want %h", Instruction_OUT, e[63:32]); end
    checks++; if (Valid_OUT !== 1'b1) begin fails++; $display("[TB] FAIL rm_next_valid: got %b want 1", Valid_OUT); end
  endtask

  initial begin
    last_instr = NOP;
    last_pc4   = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_skid();
    test_flush();
    test_timeout();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin fails++; $display("[TB] FAIL sb_leftover: got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ifid_fetch_buffer.md
Name: ifid_fetch_buffer

Overview:
- Fetch-side pipeline stage between the PC stage (IF) and decode (ID).
- Takes the current fetch address and address+4 from IF, runs a req/ack handshake with instruction memory, and registers the returned instruction into the IF/ID pipeline register.
- Holds one skid entry when ID stalls as the memory acks, and drives the STALL input of IF while a fetch is outstanding.
- Handles flush (discard in-flight fetch) and flags a bus timeout.

Parameters:
NOP_INSTR, 32'h00000000, instruction word loaded into IF/ID on reset/flush
TIMEOUT, 16, consecutive un-acked request cycles before BusError_OUT sets (>=1)

Ports:
CLOCK  input  1  system clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
InstructionAddress_IN  input  32  fetch address from IF
InstructionAddressPlus4_IN  input  32  fetch address + 4 from IF
Stall_IN  input  1  ID/hazard unit cannot accept a new instruction
Flush_IN  input  1  kill IF/ID contents and any in-flight fetch
MemReq_OUT  output  1  instruction memory request
MemAddr_OUT  output  32  instruction memory address
MemAck_IN  input  1  memory returns MemData_IN this cycle
MemData_IN  input  32  instruction word
Instruction_OUT  output  32  IF/ID instruction
InstructionAddressPlus4_OUT  output  32  IF/ID PC+4
Valid_OUT  output  1  IF/ID holds a real instruction
FetchStall_OUT  output  1  to IF STALL: hold PC
BusError_OUT  output  1  sticky timeout flag

Behaviour:
- Reset values (RESET high at clock edge):
  - state=FETCH; Instruction_OUT=NOP_INSTR; InstructionAddressPlus4_OUT=0; Valid_OUT=0; BusError_OUT=0; wait counter=0; skid empty.
  - While RESET is high, MemReq_OUT and FetchStall_OUT are forced 0.
- Priority: RESET > Flush_IN > Stall_IN > normal.
- MemAddr_OUT = InstructionAddress_IN, combinational. IF holds the address stable while FetchStall_OUT=1.
- MemReq_OUT = 1 in FETCH and DRAIN, 0 in HOLD.
- FetchStall_OUT (combinational):
  - 1 in HOLD and DRAIN.
  - 1 in FETCH when MemAck_IN=0.
  - 0 in FETCH when MemAck_IN=1 and Stall_IN=0, so IF advances the same cycle.
- FETCH:
  - Ack, no stall, no flush: load IF/ID with MemData_IN and InstructionAddressPlus4_IN, Valid_OUT=1, stay in FETCH. Zero-wait memory sustains 1 instruction/cycle.
  - Ack with Stall_IN: capture data and PC+4 into skid; IF/ID unchanged; go to HOLD.
  - No ack: IF/ID holds if Stall_IN=1, else Valid_OUT=0 (bubble). Wait counter increments.
  - Flush with ack: discard data; IF/ID=NOP_INSTR/0, Valid_OUT=0; stay in FETCH.
  - Flush without ack: clear IF/ID the same way; go to DRAIN.
- HOLD:
  - Stall_IN=0: skid moves to IF/ID, Valid_OUT=1, skid empties, go to FETCH. First new request is the next cycle.
  - Stall_IN=1: everything holds.
  - Flush: clear IF/ID, drop skid, go to FETCH.
- DRAIN:
  - MemReq_OUT held 1 on the unchanged address.
  - On ack: data discarded, go to FETCH.
  - Flush in DRAIN is a no-op.
  - Valid_OUT stays 0.
- Wait counter:
  - Width $clog2(TIMEOUT+1). Counts consecutive cycles with MemReq_OUT=1 and MemAck_IN=0.
  - Clears on ack.
  - Saturates at TIMEOUT; when it reaches TIMEOUT, BusError_OUT sets and stays set until RESET.
  - The request keeps asserting after a timeout.
- MemAck_IN while MemReq_OUT=0 (HOLD) is ignored.
- RESET mid-fetch abandons the request; the next request issues the cycle after RESET drops.

Test Plan:
- Zero-wait stream: ack every cycle, addresses 0xBFC00000/04/08, data 0x11,0x22,0x33 -> Instruction_OUT 0x11,0x22,0x33 on consecutive cycles, PC+4 0xBFC00004/08/0C, FetchStall_OUT never 1.
- Wait states: ack 3 cycles after request -> FetchStall_OUT=1 for 3 cycles, Valid_OUT=0 bubbles, then instruction loads with Valid_OUT=1.
- Skid: ack 0xAA with Stall_IN=1 held 2 cycles -> IF/ID unchanged, FetchStall_OUT=1, MemReq_OUT=0; on Stall_IN=0, Instruction_OUT=0xAA the next edge.
- Flush: Flush_IN during un-acked request, ack 0xBB 2 cycles later -> Valid_OUT=0, Instruction_OUT=0, 0xBB never appears; next fetch proceeds normally. Flush in HOLD drops skid.
- Timeout: TIMEOUT=16, no ack -> BusError_OUT rises after 16 request cycles and stays 1 after a late ack; clears only on RESET.
- Reset mid-operation: RESET in HOLD with Flush_IN and Stall_IN high -> next edge all outputs at reset values, MemReq_OUT=0 while RESET=1.
